// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter funnelling S_COUNT AXI4-lite read requesters onto one
// downstream read channel, with one transaction in flight at a time.
module axil_rd_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [S_COUNT*3-1:0]          s_axil_arprot,
  input  logic [S_COUNT-1:0]            s_axil_arvalid,
  output logic [S_COUNT-1:0]            s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [S_COUNT*2-1:0]          s_axil_rresp,
  output logic [S_COUNT-1:0]            s_axil_rvalid,
  input  logic [S_COUNT-1:0]            s_axil_rready,

  output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
  output logic [2:0]                    m_axil_arprot,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready,

  output logic [S_COUNT-1:0]            grant,
  output logic                          busy
);

  localparam int IDXW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state, state_next;
  logic [IDXW-1:0]         last_grant;
  logic [IDXW-1:0]         cur_idx;
  logic [IDXW-1:0]         win_idx;
  logic [IDXW-1:0]         cand;
  logic                    win_found;
  logic [S_COUNT-1:0]      win_onehot;
  logic [S_COUNT-1:0]      cur_onehot;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              resp_q;

  // Search starts one past the last served port so every requester gets a turn.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      cand = IDXW'((32'(last_grant) + 1 + i) % S_COUNT);
      if (!win_found && s_axil_arvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_found) win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    cur_onehot          = '0;
    cur_onehot[cur_idx] = 1'b1;
  end

  always_comb begin
    state_next     = state;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so no address is accepted while reset is held.
        if (win_found && rst_n) begin
          s_axil_arready = win_onehot;
          state_next     = ADDR;
        end
      end
      ADDR: begin
        m_axil_arvalid = 1'b1;
        if (m_axil_arready) state_next = DATA;
      end
      DATA: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) state_next = RESP;
      end
      RESP: begin
        s_axil_rvalid = cur_onehot;
        if (s_axil_rready[cur_idx]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDXW'(S_COUNT - 1);
      cur_idx    <= '0;
      addr_q     <= '0;
      prot_q     <= '0;
      data_q     <= '0;
      resp_q     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_found) begin
        cur_idx <= win_idx;
        addr_q  <= s_axil_araddr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        prot_q  <= s_axil_arprot[int'(win_idx)*3 +: 3];
      end
      if (state == DATA && m_axil_rvalid) begin
        data_q <= m_axil_rdata;
        resp_q <= m_axil_rresp;
      end
      if (state == RESP && s_axil_rready[cur_idx]) last_grant <= cur_idx;
    end
  end

  assign busy          = (state != IDLE);
  assign grant         = busy ? cur_onehot : '0;
  assign m_axil_araddr = addr_q;
  assign m_axil_arprot = prot_q;
  assign s_axil_rdata  = {S_COUNT{data_q}};
  assign s_axil_rresp  = {S_COUNT{resp_q}};

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin reference model.
module tb_axil_rd_arbiter;

  localparam int S  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*AW-1:0] s_axil_araddr = '0;
  logic [S*3-1:0]  s_axil_arprot = '0;
  logic [S-1:0]    s_axil_arvalid = '0;
  logic [S-1:0]    s_axil_arready;
  logic [S*DW-1:0] s_axil_rdata;
  logic [S*2-1:0]  s_axil_rresp;
  logic [S-1:0]    s_axil_rvalid;
  logic [S-1:0]    s_axil_rready = '0;
  logic [AW-1:0]   m_axil_araddr;
  logic [2:0]      m_axil_arprot;
  logic            m_axil_arvalid;
  logic            m_axil_arready = 1'b0;
  logic [DW-1:0]   m_axil_rdata = '0;
  logic [1:0]      m_axil_rresp = '0;
  logic            m_axil_rvalid = 1'b0;
  logic            m_axil_rready;
  logic [S-1:0]    grant;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  axil_rd_arbiter #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    s_axil_arvalid = '0; s_axil_rready = '0;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Acts as downstream slave and requester side for one read; reports what it observed.
  task automatic serve(input int ar_dly, input int r_dly, input int rr_dly,
                       input logic [31:0] key, input logic [1:0] resp,
                       output int owner, output logic [31:0] data, output logic [1:0] rsp,
                       output int lat, output int idle_wait, output bit ok);
    int ph, cnt, c;
    bit clr;
    logic [31:0] a_seen;
    owner = -1; ph = 0; cnt = 0; c = 0; ok = 1'b1; lat = -1; idle_wait = 0;
    data = '0; rsp = '0; a_seen = '0; clr = 1'b0;
    for (int k = 0; k < 200 && ph != 4; k++) begin
      m_axil_arready = (ph == 1 && cnt >= ar_dly);
      m_axil_rvalid  = (ph == 2 && cnt >= r_dly);
      m_axil_rdata   = a_seen ^ key;
      m_axil_rresp   = resp;
      s_axil_rready  = (ph == 3 && cnt >= rr_dly) ? '1 : '0;
      @(negedge clk);
      if (ph > 0) begin
        if (s_axil_arready != '0) ok = 1'b0;
        if (grant !== (4'b1 << owner) || busy !== 1'b1) ok = 1'b0;
      end
      case (ph)
        0: if (s_axil_arready != '0) begin
             if (!$onehot(s_axil_arready)) ok = 1'b0;
             for (int i = 0; i < S; i++) if (s_axil_arready[i]) owner = i;
             ph = 1; cnt = 0; c = 0; clr = 1'b1;
           end else idle_wait++;
        1: begin
             if (m_axil_rready || !m_axil_arvalid) ok = 1'b0;
             if (cnt == 0) a_seen = m_axil_araddr;
             else if (m_axil_araddr !== a_seen) ok = 1'b0;
             if (m_axil_arvalid && m_axil_arready) begin ph = 2; cnt = 0; end else cnt++;
           end
        2: begin
             if (m_axil_arvalid || !m_axil_rready || s_axil_rvalid != '0) ok = 1'b0;
             if (m_axil_rvalid) begin ph = 3; cnt = 0; end else cnt++;
           end
        default: begin
             if (m_axil_arvalid || m_axil_rready) ok = 1'b0;
             if (s_axil_rvalid !== (4'b1 << owner)) ok = 1'b0;
             if (lat < 0) begin
               lat = c; data = s_axil_rdata[owner*32 +: 32]; rsp = s_axil_rresp[owner*2 +: 2];
             end
             if (s_axil_rdata !== {S{data}} || s_axil_rresp !== {S{rsp}}) ok = 1'b0;
             if (s_axil_rready[owner]) ph = 4; else cnt++;
           end
      endcase
      @(posedge clk); #1;
      c++;
      if (clr) begin s_axil_arvalid[owner] = 1'b0; clr = 1'b0; end
    end
    if (ph != 4) ok = 1'b0;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; s_axil_rready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    s_axil_arvalid = '1;
    @(negedge clk);
    n_checks++; if (s_axil_arready !== '0) $display("FAIL reset_arready got %h want 0", s_axil_arready); else n_pass++;
    n_checks++; if (m_axil_arvalid !== 1'b0) $display("FAIL reset_m_arvalid got %b want 0", m_axil_arvalid); else n_pass++;
    n_checks++; if (m_axil_rready !== 1'b0) $display("FAIL reset_m_rready got %b want 0", m_axil_rready); else n_pass++;
    n_checks++; if (s_axil_rvalid !== '0) $display("FAIL reset_rvalid got %h want 0", s_axil_rvalid); else n_pass++;
    n_checks++; if (grant !== '0 || busy !== 1'b0) $display("FAIL reset_grant_busy got %h/%b want 0/0", grant, busy); else n_pass++;
    n_checks++; if (s_axil_rdata !== '0 || s_axil_rresp !== '0) $display("FAIL reset_rdata got %h/%h want 0", s_axil_rdata, s_axil_rresp); else n_pass++;
    s_axil_arvalid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    apply_reset();
    s_axil_araddr[0 +: 32] = 32'h100; s_axil_arprot[0 +: 3] = 3'd0; s_axil_arvalid = 4'b0001;
    serve(0, 0, 0, 32'hDEADBEEF ^ 32'h100, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 0) $display("FAIL single_owner got %0d want 0", owner); else n_pass++;
    n_checks++; if (d !== 32'hDEADBEEF) $display("FAIL single_data got %h want deadbeef", d); else n_pass++;
    n_checks++; if (lat != 3) $display("FAIL single_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (r !== 2'b00 || !ok || iw != 0) $display("FAIL single_protocol resp %b ok %0d wait %0d want 00/1/0", r, ok, iw); else n_pass++;
  endtask

  task automatic test_round_robin();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    apply_reset();
    for (int i = 0; i < S; i++) s_axil_araddr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h10;
    s_axil_arvalid = '1;
    for (int t = 0; t < 5; t++) begin
      serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
      n_checks++; if (owner != t % S) $display("FAIL rr_order[%0d] got %0d want %0d", t, owner, t % S); else n_pass++;
      n_checks++; if (d !== ((32'h1000 + 32'(t % S) * 32'h10) ^ KEY)) $display("FAIL rr_data[%0d] got %h", t, d); else n_pass++;
      n_checks++; if (!ok || iw != 0 || lat != 3) $display("FAIL rr_timing[%0d] ok %0d wait %0d lat %0d want 1/0/3", t, ok, iw, lat); else n_pass++;
      if (owner >= 0) s_axil_arvalid[owner] = 1'b1;
    end
    s_axil_arvalid = '0;
  endtask

  task automatic test_priority();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    apply_reset();
    s_axil_araddr[32 +: 32] = 32'h1000; s_axil_araddr[96 +: 32] = 32'h3000;
    s_axil_arvalid = 4'b0010;
    serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 1) $display("FAIL prio_setup got %0d want 1", owner); else n_pass++;
    s_axil_arvalid = 4'b1010;
    serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 3 || d !== (32'h3000 ^ KEY)) $display("FAIL prio_first got %0d/%h want 3", owner, d); else n_pass++;
    serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 1 || d !== (32'h1000 ^ KEY) || !ok) $display("FAIL prio_second got %0d/%h want 1", owner, d); else n_pass++;
  endtask

  task automatic test_backpressure();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    s_axil_araddr[64 +: 32] = 32'h2222_0000; s_axil_arprot[6 +: 3] = 3'd5; s_axil_arvalid = 4'b0100;
    serve(5, 1, 4, KEY, 2'b01, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 2 || d !== (32'h2222_0000 ^ KEY) || r !== 2'b01) $display("FAIL bp_result got %0d/%h/%b", owner, d, r); else n_pass++;
    n_checks++; if (!ok) $display("FAIL bp_stability got ok=%0d want 1", ok); else n_pass++;
    n_checks++; if (lat != 9) $display("FAIL bp_latency got %0d want 9", lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    s_axil_araddr[32 +: 32] = 32'h4444; s_axil_arvalid = 4'b0010;
    @(posedge clk); #1;
    s_axil_arvalid = '0; m_axil_arready = 1'b1;
    @(posedge clk); #1;
    m_axil_arready = 1'b0;
    @(negedge clk);
    n_checks++; if (m_axil_rready !== 1'b1 || grant !== 4'b0010) $display("FAIL rstmid_in_data got %b/%h want 1/2", m_axil_rready, grant); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || grant !== '0) $display("FAIL rstmid_async got busy %b grant %h want 0", busy, grant); else n_pass++;
    n_checks++; if (m_axil_rready !== 1'b0 || m_axil_arvalid !== 1'b0 || s_axil_rvalid !== '0) $display("FAIL rstmid_valids got %b%b%h want 0", m_axil_rready, m_axil_arvalid, s_axil_rvalid); else n_pass++;
    n_checks++; if (s_axil_rdata !== '0) $display("FAIL rstmid_rdata got %h want 0", s_axil_rdata); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    s_axil_arvalid = '1;
    serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 0 || !ok) $display("FAIL rstmid_next got %0d ok %0d want 0/1", owner, ok); else n_pass++;
    s_axil_arvalid = '0;
  endtask

  task automatic test_slverr();
    int owner, lat, iw; logic [31:0] d; logic [1:0] r; bit ok;
    apply_reset();
    s_axil_araddr[96 +: 32] = 32'h9000; s_axil_arvalid = 4'b1000;
    serve(0, 2, 1, KEY, 2'b10, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 3 || r !== 2'b10 || !ok) $display("FAIL slverr_resp got %0d/%b want 3/10", owner, r); else n_pass++;
    s_axil_araddr[0 +: 32] = 32'h0ABC; s_axil_arvalid = 4'b0001;
    serve(0, 0, 0, KEY, 2'b00, owner, d, r, lat, iw, ok);
    n_checks++; if (owner != 0 || r !== 2'b00 || d !== (32'h0ABC ^ KEY) || !ok) $display("FAIL slverr_after got %0d/%b/%h", owner, r, d); else n_pass++;
  endtask

  // Reference model: a transaction owns the channel from grant until the requester takes
  // its response; the next owner is the first requesting port after the last one served.
  task automatic test_random();
    int owner, last, ph, w;
    int waits[S];
    logic [31:0] a_exp, d_exp; logic [2:0] p_exp; logic [1:0] r_exp;
    logic [S-1:0] exp_v;
    apply_reset();
    owner = -1; last = S - 1; ph = 0; a_exp = '0; d_exp = '0; p_exp = '0; r_exp = '0;
    for (int i = 0; i < S; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < S; i++)
        if (!s_axil_arvalid[i] && $urandom_range(0, 2) == 0) begin
          s_axil_arvalid[i] = 1'b1;
          s_axil_araddr[i*32 +: 32] = $urandom;
          s_axil_arprot[i*3 +: 3] = 3'($urandom);
        end
      m_axil_arready = 1'($urandom); m_axil_rvalid = 1'($urandom);
      m_axil_rdata = $urandom; m_axil_rresp = 2'($urandom);
      s_axil_rready = 4'($urandom);
      @(negedge clk);
      w = -1;
      if (owner < 0)
        for (int k = 1; k <= S && w < 0; k++)
          if (s_axil_arvalid[(last + k) % S]) w = (last + k) % S;
      exp_v = (w >= 0) ? (4'b1 << w) : '0;
      n_checks++; if (s_axil_arready !== exp_v) $display("FAIL rnd_arready c%0d got %h want %h", cyc, s_axil_arready, exp_v); else n_pass++;
      exp_v = (owner >= 0) ? (4'b1 << owner) : '0;
      n_checks++; if (grant !== exp_v || busy !== (owner >= 0)) $display("FAIL rnd_grant c%0d got %h/%b want %h", cyc, grant, busy, exp_v); else n_pass++;
      n_checks++; if (m_axil_arvalid !== (ph == 1) || m_axil_rready !== (ph == 2)) $display("FAIL rnd_down c%0d got %b%b phase %0d", cyc, m_axil_arvalid, m_axil_rready, ph); else n_pass++;
      if (ph == 1) begin
        n_checks++; if (m_axil_araddr !== a_exp || m_axil_arprot !== p_exp) $display("FAIL rnd_addr c%0d got %h/%0d want %h/%0d", cyc, m_axil_araddr, m_axil_arprot, a_exp, p_exp); else n_pass++;
      end
      exp_v = (ph == 3) ? (4'b1 << owner) : '0;
      n_checks++; if (s_axil_rvalid !== exp_v) $display("FAIL rnd_rvalid c%0d got %h want %h", cyc, s_axil_rvalid, exp_v); else n_pass++;
      if (ph == 3) begin
        n_checks++; if (s_axil_rdata !== {S{d_exp}} || s_axil_rresp !== {S{r_exp}}) $display("FAIL rnd_rdata c%0d got %h/%h want %h/%b", cyc, s_axil_rdata[31:0], s_axil_rresp, d_exp, r_exp); else n_pass++;
      end
      if (w >= 0) begin
        n_checks++; if (waits[w] > S - 1) $display("FAIL rnd_fairness port %0d waited %0d want <=%0d", w, waits[w], S - 1); else n_pass++;
        for (int i = 0; i < S; i++) if (i != w && s_axil_arvalid[i]) waits[i]++;
        waits[w] = 0;
        owner = w; a_exp = s_axil_araddr[w*32 +: 32]; p_exp = s_axil_arprot[w*3 +: 3]; ph = 1;
      end else if (ph == 1 && m_axil_arready) ph = 2;
      else if (ph == 2 && m_axil_rvalid) begin d_exp = m_axil_rdata; r_exp = m_axil_rresp; ph = 3; end
      else if (ph == 3 && s_axil_rready[owner]) begin last = owner; owner = -1; ph = 0; end
      @(posedge clk); #1;
      if (w >= 0) s_axil_arvalid[w] = 1'b0;
    end
    s_axil_arvalid = '0; s_axil_rready = '0; m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_slverr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
